// File: rtl/argmax_scan_unit.sv
// Argmax scanner: reads NUM_CLASSES signed logits from a synchronous-read score RAM and reports
// the winning index and score. Define ARGMAX_MARGIN_EN to add the top/second margin check (low_conf).
module argmax_scan_unit #(
    parameter int NUM_CLASSES   = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int MARGIN_THRESH = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] score_addr,
    input  logic [DATA_WIDTH-1:0] score_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            argmax_out,
    output logic [DATA_WIDTH-1:0] max_score,
    output logic                  low_conf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CLASSES - 1);
    localparam logic [3:0]            NO_RESULT = 4'd10;

    if (NUM_CLASSES < 2 || NUM_CLASSES > 15 || (1 << ADDR_WIDTH) < NUM_CLASSES ||
        MARGIN_THRESH < 0) begin : g_bad_params
        $error("argmax_scan_unit: illegal parameter combination");
    end

    logic [1:0]                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic                          valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]         idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]  best_q, best_d;
    logic [ADDR_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic [3:0]                    argmax_q, argmax_d;
    logic [DATA_WIDTH-1:0]         max_q, max_d;
    logic signed [DATA_WIDTH-1:0]  sample;

    assign sample = $signed(score_data);

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [DATA_WIDTH:0] THRESH = (DATA_WIDTH + 1)'(MARGIN_THRESH);

    logic signed [DATA_WIDTH-1:0]  second_q, second_d;
    logic                          second_vld_q, second_vld_d;
    logic                          low_conf_q, low_conf_d;
    logic signed [DATA_WIDTH:0]    margin;
`endif

    // valid_q/idx_q mark that score_data carries the logit addressed one cycle earlier.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = (state_q == ST_SCAN);
        idx_d      = addr_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        argmax_d   = argmax_q;
        max_d      = max_q;
`ifdef ARGMAX_MARGIN_EN
        second_d     = second_q;
        second_vld_d = second_vld_q;
        low_conf_d   = low_conf_q;
        margin       = '0;
`endif

        if (valid_q) begin
            if (idx_q == '0) begin
                best_d     = sample;
                best_idx_d = '0;
`ifdef ARGMAX_MARGIN_EN
                second_vld_d = 1'b0;
`endif
            end else if (sample > best_q) begin
`ifdef ARGMAX_MARGIN_EN
                second_d     = best_q;
                second_vld_d = 1'b1;
`endif
                best_d     = sample;
                best_idx_d = idx_q;
            end
`ifdef ARGMAX_MARGIN_EN
            else if (!second_vld_q || sample > second_q) begin
                second_d     = sample;
                second_vld_d = 1'b1;
            end
`endif
        end

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last logit is folded in on this same edge, so publish the *_d values.
                state_d  = ST_DONE;
                argmax_d = 4'(best_idx_d);
                max_d    = best_d;
`ifdef ARGMAX_MARGIN_EN
                margin     = {best_d[DATA_WIDTH-1], best_d} - {second_d[DATA_WIDTH-1], second_d};
                low_conf_d = (margin < THRESH);
                if (margin < THRESH) argmax_d = NO_RESULT;
`endif
            end
            ST_DONE: begin
                addr_d = '0;
                if (!start) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            argmax_q   <= NO_RESULT;
            max_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q     <= '0;
            second_vld_q <= 1'b0;
            low_conf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            argmax_q   <= argmax_d;
            max_q      <= max_d;
`ifdef ARGMAX_MARGIN_EN
            second_q     <= second_d;
            second_vld_q <= second_vld_d;
            low_conf_q   <= low_conf_d;
`endif
        end
    end

    assign score_addr = addr_q;
    assign busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign argmax_out = argmax_q;
    assign max_score  = max_q;
`ifdef ARGMAX_MARGIN_EN
    assign low_conf   = low_conf_q;
`else
    assign low_conf   = 1'b0;
`endif

endmodule
